// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, widths and writer/reader FSM encodings
package fb_pkg;
  localparam int FB_WIDTH          = 320;
  localparam int FB_LINES_PER_BANK = 16;
  localparam int FB_NUM_BANKS      = 15;
  localparam int FB_DEPTH          = FB_WIDTH * FB_LINES_PER_BANK;
  localparam int FB_ADDR_WIDTH     = 13;
  localparam int FB_DATA_WIDTH     = 12;
  localparam int FB_BANK_WIDTH     = 4;
  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_WRITE = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: intra-bank address and bank counters with wrap, clear, sof load and last flag
module fb_addr_gen #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 5120,
  parameter int NUM_BANKS  = 15,
  parameter int BANK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_adv,
  input  logic                  i_sof,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [BANK_WIDTH-1:0] o_bank,
  output logic                  o_last,
  output logic                  o_origin
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic                  addr_end;
  always_comb begin
    addr_end = addr_q == ADDR_WIDTH'(DEPTH - 1);
    o_last   = addr_end && bank_q == BANK_WIDTH'(NUM_BANKS - 1);
    o_origin = addr_q == '0 && bank_q == '0;
    o_addr   = addr_q;
    o_bank   = bank_q;
    addr_d   = addr_q;
    bank_d   = bank_q;
    if (i_clr) begin
      addr_d = '0;
      bank_d = '0;
    end else if (i_adv) begin
      // a sof pixel lands at (0,0), so the next pixel goes to (0,1)
      addr_d = i_sof ? ADDR_WIDTH'(1) : addr_end ? '0 : addr_q + ADDR_WIDTH'(1);
      bank_d = i_sof || o_last ? '0 : addr_end ? bank_q + BANK_WIDTH'(1) : bank_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      bank_q <= '0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end
endmodule

// File: rtl/fb_bank_writer.sv
// fb_bank_writer: raster RGB444 stream to one-hot banked blockram port-A writes
module fb_bank_writer
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DEPTH      = FB_DEPTH,
  parameter int NUM_BANKS  = FB_NUM_BANKS,
  parameter int BANK_WIDTH = FB_BANK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [NUM_BANKS-1:0]  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_sync_err
);
  fb_state_e             state_q, state_d;
  logic                  accept, clr, last, origin;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic [BANK_WIDTH-1:0] cnt_bank;
  logic [NUM_BANKS-1:0]  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sync_err_q, sync_err_d;
  fb_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .NUM_BANKS (NUM_BANKS),
    .BANK_WIDTH(BANK_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr),
    .i_adv   (accept),
    .i_sof   (i_sof),
    .o_addr  (cnt_addr),
    .o_bank  (cnt_bank),
    .o_last  (last),
    .o_origin(origin)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FB_IDLE;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sync_err_q <= sync_err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FB_IDLE:  state_d = i_start ? FB_WRITE : FB_IDLE;
      FB_WRITE: state_d = accept && !i_sof && last ? FB_DONE : FB_WRITE;
      FB_DONE:  state_d = FB_IDLE;
      default:  state_d = FB_IDLE;
    endcase
  end
  always_comb begin
    o_ready      = state_q == FB_WRITE;
    o_busy       = state_q == FB_WRITE;
    o_frame_done = state_q == FB_DONE;
    accept       = i_valid && o_ready;
    clr          = state_q == FB_IDLE && i_start;
    we_d         = accept ? NUM_BANKS'(1) << (i_sof ? '0 : cnt_bank) : '0;
    addr_d       = accept ? (i_sof ? '0 : cnt_addr) : addr_q;
    data_d       = accept ? i_data : data_q;
    sync_err_d   = accept && i_sof && !origin;
    o_we         = we_q;
    o_addr       = addr_q;
    o_data       = data_q;
    o_sync_err   = sync_err_q;
  end
endmodule

// File: tb/tb_fb_bank_writer.sv
// tb_fb_bank_writer: directed and randomized stimulus against a linear-pixel-index reference model
module tb_fb_bank_writer;
  localparam int DEPTH = 5120;
  localparam int NB    = 15;
  localparam int TOTAL = DEPTH * NB;
  logic        clk, rst_n, i_start, i_valid, i_sof, o_ready, o_busy, o_frame_done, o_sync_err;
  logic [11:0] i_data, o_data;
  logic [14:0] o_we;
  logic [12:0] o_addr;
  int checks, failures, fd_cnt;
  int ms, pos;
  logic [14:0] e_we;
  logic [12:0] e_addr;
  logic [11:0] e_data;
  logic        e_sync;
  bit          sof_done;
  fb_bank_writer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_data(i_data), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_sync_err(o_sync_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cycle(input logic v, input logic sof, input logic start, input logic [11:0] d);
    bit acc;
    int p;
    i_valid = v; i_sof = sof; i_start = start; i_data = d;
    #1;
    chk("ready_pre", o_ready, ms == 1);
    acc = ms == 1 && v;
    p = pos;
    @(posedge clk); #1;
    e_we = '0;
    if (acc) begin
      e_we   = 15'(1) << (sof ? 0 : p / DEPTH);
      e_addr = sof ? 13'd0 : 13'(p % DEPTH);
      e_data = d;
    end
    e_sync = acc && sof && p != 0;
    if (ms == 0 && start) begin
      ms = 1; pos = 0;
    end else if (ms == 1 && acc) begin
      if (!sof && p == TOTAL - 1) ms = 2;
      pos = sof ? 1 : p + 1;
    end else if (ms == 2) ms = 0;
    chk("we", o_we, e_we);
    chk("addr", o_addr, e_addr);
    chk("data", o_data, e_data);
    chk("sync_err", o_sync_err, e_sync);
    chk("frame_done", o_frame_done, ms == 2);
    chk("busy", o_busy, ms == 1);
    chk("onehot0", $onehot0(o_we), 1);
    if (acc && !sof && p == DEPTH - 1) begin
      chk("wrap_we_5119", o_we, 15'h0001);
      chk("wrap_addr_5119", o_addr, 13'd5119);
    end
    if (acc && !sof && p == DEPTH) begin
      chk("wrap_we_5120", o_we, 15'h0002);
      chk("wrap_addr_5120", o_addr, 13'd0);
    end
    if (o_frame_done) fd_cnt++;
  endtask
  task automatic reset_mid();
    rst_n = 1'b0;
    #2;
    ms = 0; pos = 0; e_we = '0; e_addr = '0; e_data = '0; e_sync = 1'b0;
    chk("rst_we", o_we, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_sync", o_sync_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  initial begin
    checks = 0; failures = 0; fd_cnt = 0; sof_done = 0;
    rst_n = 1'b1; i_start = 0; i_valid = 0; i_sof = 0; i_data = '0;
    @(posedge clk); #1;
    reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 12'(i));
    cycle(1, 0, 1, 12'hfff);
    for (int i = 0; i < TOTAL + 10 && ms != 0; i++) cycle(1, 0, ms == 2, 12'(pos));
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_end_busy", o_busy, 0);
    for (int i = 0; i < 100; i++) cycle(1, 0, 0, 12'($urandom));
    cycle(0, 0, 1, 12'h0);
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 0, $urandom_range(0, 15) == 0, 12'($urandom));
    for (int i = 0; i < 6000 && pos < DEPTH + 10; i++) begin
      cycle(1, pos == 1000 && !sof_done, 0, 12'($urandom));
      if (e_sync) sof_done = 1;
    end
    chk("sof_seen", sof_done, 1);
    cycle(1, 0, 0, 12'h5a5);
    reset_mid();
    cycle(1, 0, 1, 12'h123);
    cycle(1, 0, 0, 12'h321);
    chk("restart_we", o_we, 15'h0001);
    chk("restart_addr", o_addr, 13'd0);
    for (int i = 0; i < 200; i++) cycle(1'($urandom_range(0, 1)), 0, 0, 12'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
